// File: rtl/jhash_pkg.sv
// Shared definitions for the lookup3 hashword engine: FSM encoding, sub-step
// mode, golden constant and the fixed rotation tables.
package jhash_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MIX   = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } jh_state_e;

  typedef enum logic {
    MODE_MIX   = 1'b0,
    MODE_FINAL = 1'b1
  } jh_mode_e;

  localparam logic [31:0] JHASH_GOLDEN = 32'hdeadbeef;
  localparam int MIX_STEPS   = 6;
  localparam int FINAL_STEPS = 7;

  localparam int unsigned MIX_ROT   [6] = '{4, 6, 8, 16, 19, 4};
  localparam int unsigned FINAL_ROT [7] = '{14, 11, 25, 16, 4, 14, 24};

  // Always called with a table constant, so this reduces to wiring.
  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/jhash_step.sv
// One combinational lookup3 sub-step (mix or final) selected by step index;
// passes a/b/c through unchanged when disabled.
module jhash_step
  import jhash_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [3:0]  idx_i,
  input  jh_mode_e    mode_i,
  input  logic        en_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o
);

  always_comb begin
    a_o = a_i;
    b_o = b_i;
    c_o = c_i;
    if (en_i && mode_i == MODE_MIX) begin
      case (idx_i)
        4'd0: begin a_o = (a_i - c_i) ^ rotl(c_i, MIX_ROT[0]); c_o = c_i + b_i; end
        4'd1: begin b_o = (b_i - a_i) ^ rotl(a_i, MIX_ROT[1]); a_o = a_i + c_i; end
        4'd2: begin c_o = (c_i - b_i) ^ rotl(b_i, MIX_ROT[2]); b_o = b_i + a_i; end
        4'd3: begin a_o = (a_i - c_i) ^ rotl(c_i, MIX_ROT[3]); c_o = c_i + b_i; end
        4'd4: begin b_o = (b_i - a_i) ^ rotl(a_i, MIX_ROT[4]); a_o = a_i + c_i; end
        4'd5: begin c_o = (c_i - b_i) ^ rotl(b_i, MIX_ROT[5]); b_o = b_i + a_i; end
        default: ;
      endcase
    end else if (en_i) begin
      case (idx_i)
        4'd0: c_o = (c_i ^ b_i) - rotl(b_i, FINAL_ROT[0]);
        4'd1: a_o = (a_i ^ c_i) - rotl(c_i, FINAL_ROT[1]);
        4'd2: b_o = (b_i ^ a_i) - rotl(a_i, FINAL_ROT[2]);
        4'd3: c_o = (c_i ^ b_i) - rotl(b_i, FINAL_ROT[3]);
        4'd4: a_o = (a_i ^ c_i) - rotl(c_i, FINAL_ROT[4]);
        4'd5: b_o = (b_i ^ a_i) - rotl(a_i, FINAL_ROT[5]);
        4'd6: c_o = (c_i ^ b_i) - rotl(b_i, FINAL_ROT[6]);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/jhash_engine.sv
// lookup3 hashword2() engine: consumes 3-word beats for a commanded length,
// running STEPS mix/final sub-steps per clock, and returns c (primary) and b.
module jhash_engine
  import jhash_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      cmd_init,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data0,
  input  logic [31:0]      in_data1,
  input  logic [31:0]      in_data2,
  input  logic [1:0]       in_cnt,
  input  logic             in_last,
  output logic             hash_valid,
  input  logic             hash_ready,
  output logic [31:0]      hash_c,
  output logic [31:0]      hash_b,
  output logic             hash_err
);

  jh_state_e        state_q, state_d;
  logic [31:0]      a_q, b_q, c_q, a_d, b_d, c_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [3:0]       base_q, base_d;
  logic             err_q, err_d;

  jh_mode_e              mode;
  logic [3:0]            limit;
  logic [3:0]            base_nx;
  logic [STEPS:0][31:0]  ca, cb, cc;
  logic                  full;
  logic [1:0]            cnt_exp;
  logic [31:0]           init_val;

  assign mode     = (state_q == S_FINAL) ? MODE_FINAL : MODE_MIX;
  assign limit    = (mode == MODE_FINAL) ? 4'(FINAL_STEPS) : 4'(MIX_STEPS);
  assign base_nx  = base_q + 4'(STEPS);
  assign full     = rem_q > LEN_W'(3);
  assign cnt_exp  = full ? 2'd3 : rem_q[1:0];
  assign init_val = JHASH_GOLDEN + 32'({cmd_len, 2'b00}) + cmd_init;

  assign ca[0] = a_q;
  assign cb[0] = b_q;
  assign cc[0] = c_q;

  // Sub-steps past the end of the round (only possible in FINAL) pass through.
  for (genvar i = 0; i < STEPS; i++) begin : g_step
    logic [3:0] idx;
    assign idx = base_q + 4'(i);
    jhash_step u_step (
      .a_i   (ca[i]),
      .b_i   (cb[i]),
      .c_i   (cc[i]),
      .idx_i (idx),
      .mode_i(mode),
      .en_i  (idx < limit),
      .a_o   (ca[i+1]),
      .b_o   (cb[i+1]),
      .c_o   (cc[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    rem_d   = rem_q;
    base_d  = base_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          a_d     = init_val;
          b_d     = init_val;
          c_d     = init_val;
          rem_d   = cmd_len;
          err_d   = 1'b0;
          base_d  = '0;
          state_d = (cmd_len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          a_d    = a_q + in_data0;
          base_d = '0;
          if (full) begin
            b_d     = b_q + in_data1;
            c_d     = c_q + in_data2;
            rem_d   = rem_q - LEN_W'(3);
            state_d = S_MIX;
          end else begin
            if (rem_q >= LEN_W'(2)) b_d = b_q + in_data1;
            if (rem_q == LEN_W'(3)) c_d = c_q + in_data2;
            state_d = S_FINAL;
          end
          // Framing is only reported; the hash stays driven by cmd_len.
          if (in_cnt != cnt_exp || in_last == full) err_d = 1'b1;
        end
      end
      S_MIX, S_FINAL: begin
        a_d    = ca[STEPS];
        b_d    = cb[STEPS];
        c_d    = cc[STEPS];
        base_d = base_nx;
        if (base_nx >= limit) state_d = (state_q == S_MIX) ? S_LOAD : S_DONE;
      end
      S_DONE: begin
        if (hash_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      rem_q   <= '0;
      base_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      rem_q   <= rem_d;
      base_q  <= base_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign in_ready   = (state_q == S_LOAD);
  assign hash_valid = (state_q == S_DONE);
  assign hash_c     = hash_valid ? c_q : '0;
  assign hash_b     = hash_valid ? b_q : '0;
  assign hash_err   = hash_valid & err_q;

endmodule

// File: tb/tb_jhash_engine.sv
// Bench for jhash_engine: three instances (STEPS=1,2,3) checked against a
// C-style hashword2() reference model.
module tb_jhash_engine;

  logic clk = 1'b0;
  logic rst_n;

  logic [2:0]       cmd_valid, cmd_ready, in_valid, in_ready, in_last;
  logic [2:0]       hash_valid, hash_ready, hash_err;
  logic [2:0][15:0] cmd_len;
  logic [2:0][31:0] cmd_init, d0, d1, d2, hash_c, hash_b;
  logic [2:0][1:0]  in_cnt;

  logic [31:0] wbuf [64];
  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    jhash_engine #(.LEN_W(16), .STEPS(g + 1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid[g]),
      .cmd_ready (cmd_ready[g]),
      .cmd_len   (cmd_len[g]),
      .cmd_init  (cmd_init[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data0  (d0[g]),
      .in_data1  (d1[g]),
      .in_data2  (d2[g]),
      .in_cnt    (in_cnt[g]),
      .in_last   (in_last[g]),
      .hash_valid(hash_valid[g]),
      .hash_ready(hash_ready[g]),
      .hash_c    (hash_c[g]),
      .hash_b    (hash_b[g]),
      .hash_err  (hash_err[g])
    );
  end

  function automatic logic [31:0] rot(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Straight transcription of lookup3 hashword2() with *pb = 0.
  function automatic void ref_hash(input int len, input logic [31:0] init,
                                   output logic [31:0] rc, output logic [31:0] rb);
    logic [31:0] a, b, c;
    int n, p;
    a = 32'hdeadbeef + (32'(len) << 2) + init;
    b = a; c = a; n = len; p = 0;
    while (n > 3) begin
      a += wbuf[p]; b += wbuf[p+1]; c += wbuf[p+2];
      a -= c; a ^= rot(c, 4);  c += b;
      b -= a; b ^= rot(a, 6);  a += c;
      c -= b; c ^= rot(b, 8);  b += a;
      a -= c; a ^= rot(c, 16); c += b;
      b -= a; b ^= rot(a, 19); a += c;
      c -= b; c ^= rot(b, 4);  b += a;
      n -= 3; p += 3;
    end
    if (n >= 3) c += wbuf[p+2];
    if (n >= 2) b += wbuf[p+1];
    if (n >= 1) a += wbuf[p];
    if (n > 0) begin
      c ^= b; c -= rot(b, 14);
      a ^= c; a -= rot(c, 11);
      b ^= a; b -= rot(a, 25);
      c ^= b; c -= rot(b, 16);
      a ^= c; a -= rot(c, 4);
      b ^= a; b -= rot(a, 14);
      c ^= b; c -= rot(b, 24);
    end
    rc = c; rb = b;
  endfunction

  function automatic int ceil_div(input int x, input int y);
    return (x + y - 1) / y;
  endfunction

  // Drives one complete job on instance k; post_bad flags an unstable result
  // during hold or cmd_ready not returning right after the handshake.
  task automatic run_job(input int k, input int len, input logic [31:0] init,
                         input bit stall, input bit bad_last,
                         output logic [31:0] rc, output logic [31:0] rb, output logic rerr,
                         output int beats, output int lat, output int rdy_cyc,
                         output bit timeout, output bit post_bad);
    int p, rem, t, n_hold;
    bit take;
    beats = 0; lat = 0; rdy_cyc = 0; timeout = 0; post_bad = 0;
    rc = '0; rb = '0; rerr = 1'b0;
    @(negedge clk);
    cmd_len[k] = 16'(len); cmd_init[k] = init; cmd_valid[k] = 1'b1;
    t = 0;
    while (!cmd_ready[k] && t < 50) begin @(negedge clk); t++; end
    if (!cmd_ready[k]) begin cmd_valid[k] = 1'b0; timeout = 1; return; end
    @(posedge clk); #1 cmd_valid[k] = 1'b0;
    lat = 1; p = 0; rem = len; t = 0;
    forever begin
      @(negedge clk);
      if (hash_valid[k]) break;
      if (t > 3000) begin in_valid[k] = 1'b0; timeout = 1; return; end
      in_valid[k] = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      d0[k] = wbuf[p]; d1[k] = wbuf[p+1]; d2[k] = wbuf[p+2];
      in_cnt[k]  = (rem >= 3) ? 2'd3 : (rem > 0 ? 2'(rem) : 2'd0);
      in_last[k] = (rem <= 3);
      if (bad_last && rem > 0 && rem <= 3) begin in_cnt[k] = 2'd3; in_last[k] = 1'b0; end
      if (in_ready[k]) rdy_cyc++;
      take = in_valid[k] && in_ready[k];
      @(posedge clk);
      lat++; t++;
      if (take) begin beats++; p += 3; rem -= 3; end
    end
    in_valid[k] = 1'b0;
    rc = hash_c[k]; rb = hash_b[k]; rerr = hash_err[k];
    n_hold = stall ? $urandom_range(0, 4) : 0;
    for (int h = 0; h < n_hold; h++) begin
      @(posedge clk); @(negedge clk);
      if (!hash_valid[k] || hash_c[k] !== rc || hash_b[k] !== rb || hash_err[k] !== rerr)
        post_bad = 1;
    end
    hash_ready[k] = 1'b1;
    @(posedge clk); #1 hash_ready[k] = 1'b0;
    @(negedge clk);
    if (!cmd_ready[k] || hash_valid[k]) post_bad = 1;
  endtask

  task automatic test_reset(input string tag);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if ({cmd_ready[k], in_ready[k], hash_valid[k], hash_err[k]} !== 4'b1000 ||
          hash_c[k] !== 32'h0 || hash_b[k] !== 32'h0)
        $display("FAIL %s k=%0d: got rdy/in/vld/err=%b c=%h b=%h want 1000 c=0 b=0", tag, k,
                 {cmd_ready[k], in_ready[k], hash_valid[k], hash_err[k]}, hash_c[k], hash_b[k]);
      else n_pass++;
    end
  endtask

  task automatic test_len0();
    logic [31:0] rc, rb; logic re; int bt, lat, rdy; bit to, pb;
    run_job(0, 0, 32'h0, 0, 0, rc, rb, re, bt, lat, rdy, to, pb);
    n_chk++;
    if (to || rc !== 32'hdeadbeef || rb !== 32'hdeadbeef || re !== 1'b0)
      $display("FAIL len0_init0: got to=%0d c=%h b=%h err=%b want c=deadbeef b=deadbeef err=0", to, rc, rb, re);
    else n_pass++;
    n_chk++;
    if (lat !== 1 || rdy !== 0 || bt !== 0 || pb)
      $display("FAIL len0_timing: got lat=%0d rdy=%0d beats=%0d post=%0d want 1 0 0 0", lat, rdy, bt, pb);
    else n_pass++;
    run_job(0, 0, 32'hdeadbeef, 1, 0, rc, rb, re, bt, lat, rdy, to, pb);
    n_chk++;
    if (to || rc !== 32'hbd5b7dde || rb !== 32'hbd5b7dde || rdy !== 0 || pb)
      $display("FAIL len0_initdb: got c=%h b=%h rdy=%0d post=%0d want c=bd5b7dde b=bd5b7dde rdy=0", rc, rb, rdy, pb);
    else n_pass++;
  endtask

  task automatic test_len3();
    logic [31:0] rc, rb, ec, eb; logic re; int bt, lat, rdy; bit to, pb;
    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3;
    for (int i = 3; i < 64; i++) wbuf[i] = $urandom;
    ref_hash(3, 32'h0, ec, eb);
    run_job(0, 3, 32'h0, 0, 0, rc, rb, re, bt, lat, rdy, to, pb);
    n_chk++;
    if (to || rc !== ec || rb !== eb || re !== 1'b0)
      $display("FAIL len3_hash: got c=%h b=%h err=%b want c=%h b=%h err=0", rc, rb, re, ec, eb);
    else n_pass++;
    n_chk++;
    if (lat !== 9 || bt !== 1 || rdy !== 1 || pb)
      $display("FAIL len3_timing: got lat=%0d beats=%0d rdy=%0d post=%0d want 9 1 1 0", lat, bt, rdy, pb);
    else n_pass++;
  endtask

  task automatic test_steps_len7();
    logic [31:0] rc, rb, ec, eb, init; logic re; int bt, lat, rdy, elat; bit to, pb;
    logic [2:0][31:0] got_c;
    for (int trial = 0; trial < 3; trial++) begin
      for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
      init = $urandom;
      ref_hash(7, init, ec, eb);
      for (int k = 0; k < 3; k++) begin
        run_job(k, 7, init, 1, 0, rc, rb, re, bt, lat, rdy, to, pb);
        got_c[k] = rc;
        n_chk++;
        if (to || rc !== ec || rb !== eb || re !== 1'b0 || bt !== 3 || pb)
          $display("FAIL len7_steps%0d: got c=%h b=%h err=%b beats=%0d post=%0d want c=%h b=%h err=0 beats=3",
                   k + 1, rc, rb, re, bt, pb, ec, eb);
        else n_pass++;
      end
      n_chk++;
      if (got_c[1] !== got_c[0] || got_c[2] !== got_c[0])
        $display("FAIL len7_cross: got c1=%h c2=%h c3=%h want all equal", got_c[0], got_c[1], got_c[2]);
      else n_pass++;
    end
    for (int k = 0; k < 3; k++) begin
      init = $urandom;
      ref_hash(7, init, ec, eb);
      run_job(k, 7, init, 0, 0, rc, rb, re, bt, lat, rdy, to, pb);
      elat = 1 + 2 * (1 + ceil_div(6, k + 1)) + 1 + ceil_div(7, k + 1);
      n_chk++;
      if (to || lat !== elat || rc !== ec || rb !== eb)
        $display("FAIL len7_lat_steps%0d: got lat=%0d c=%h b=%h want lat=%0d c=%h b=%h",
                 k + 1, lat, rc, rb, elat, ec, eb);
      else n_pass++;
    end
  endtask

  task automatic test_framing();
    logic [31:0] rc, rb, ec, eb, init; logic re; int bt, lat, rdy; bit to, pb;
    for (int k = 0; k < 3; k += 2) begin
      for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
      init = $urandom;
      ref_hash(4, init, ec, eb);
      run_job(k, 4, init, 0, 1, rc, rb, re, bt, lat, rdy, to, pb);
      n_chk++;
      if (to || rc !== ec || rb !== eb || bt !== 2)
        $display("FAIL framing_hash_k%0d: got c=%h b=%h beats=%0d want c=%h b=%h beats=2", k, rc, rb, bt, ec, eb);
      else n_pass++;
      n_chk++;
      if (re !== 1'b1)
        $display("FAIL framing_err_k%0d: got err=%b want 1", k, re);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] rc, rb, ec, eb, init; logic re; int bt, lat, rdy, len, k; bit to, pb;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
      len  = $urandom_range(1, 30);
      k    = $urandom_range(0, 2);
      init = $urandom;
      ref_hash(len, init, ec, eb);
      run_job(k, len, init, 1, 0, rc, rb, re, bt, lat, rdy, to, pb);
      n_chk++;
      if (to || rc !== ec || rb !== eb || re !== 1'b0 || bt !== ceil_div(len, 3) || pb)
        $display("FAIL random_len%0d_steps%0d: got c=%h b=%h err=%b beats=%0d post=%0d want c=%h b=%h err=0 beats=%0d",
                 len, k + 1, rc, rb, re, bt, pb, ec, eb, ceil_div(len, 3));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rc, rb, ec, eb; logic re; int bt, lat, rdy; bit to, pb;
    for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
    @(negedge clk);
    cmd_len[0] = 16'd10; cmd_init[0] = $urandom; cmd_valid[0] = 1'b1;
    @(posedge clk); #1 cmd_valid[0] = 1'b0;
    @(negedge clk);
    d0[0] = wbuf[0]; d1[0] = wbuf[1]; d2[0] = wbuf[2];
    in_cnt[0] = 2'd3; in_last[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1 in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    test_reset("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    wbuf[0] = 32'h0;
    ref_hash(1, 32'h0, ec, eb);
    run_job(0, 1, 32'h0, 0, 0, rc, rb, re, bt, lat, rdy, to, pb);
    n_chk++;
    if (to || rc !== ec || rb !== eb || re !== 1'b0 || bt !== 1)
      $display("FAIL after_reset_len1: got c=%h b=%h err=%b beats=%0d want c=%h b=%h err=0 beats=1",
               rc, rb, re, bt, ec, eb);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = '0; in_valid = '0; in_last = '0; hash_ready = '0;
    cmd_len = '0; cmd_init = '0; d0 = '0; d1 = '0; d2 = '0; in_cnt = '0;
    for (int i = 0; i < 64; i++) wbuf[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset("reset");
    rst_n = 1'b1;
    test_len0();
    test_len3();
    test_steps_len7();
    test_framing();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jhash_engine.md
Name: jhash_engine

Overview:
- Parametrised successor to the single-mix Jenkins core: a complete lookup3 hashword() engine for variable-length 32-bit word streams.
- Provides a per-command length and initval, the mix/final split on tail words, and a configurable number of mix/final steps per cycle.
- Returns both hash words (c primary, b secondary, as in hashword2).
- Sits between the stream packer (3-word beats) and the dedup/lookup index logic.

Parameters:
- LEN_W, 16, width of cmd_len (length in 32-bit words); legal 1..30.
- STEPS, 1, lookup3 sub-steps per clock; legal values 1, 2, 3.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  start request
- cmd_ready  out  1  engine idle, command accepted when cmd_valid&&cmd_ready
- cmd_len  in  LEN_W  message length in words
- cmd_init  in  32  initval
- in_valid  in  1  data beat valid
- in_ready  out  1  data beat accepted when in_valid&&in_ready
- in_data0/1/2  in  32 each  words k[0], k[1], k[2] of beat
- in_cnt  in  2  valid words in beat (3 except last beat)
- in_last  in  1  final beat marker
- hash_valid  out  1  result available, held until hash_ready
- hash_ready  in  1  result consumed
- hash_c  out  32  primary hash
- hash_b  out  32  secondary hash
- hash_err  out  1  framing error flag, qualified by hash_valid

Behaviour:
- Reset (async, rst_n low): state IDLE; cmd_ready=1, in_ready=0, hash_valid=0, hash_err=0, hash_c=hash_b=0.
- States: IDLE, LOAD, MIX, FINAL, DONE.
- IDLE: on accept, a=b=c = 32'hdeadbeef + (cmd_len<<2) + cmd_init, all mod 2^32; rem=cmd_len; err=0. Next state DONE if cmd_len==0, else LOAD. cmd_ready=1 only in IDLE.
- LOAD: in_ready=1.
  - On beat with rem>3: a+=d0, b+=d1, c+=d2; rem-=3; go MIX.
  - On beat with rem<=3: add only the first rem words (d0->a, d1->b, d2->c); go FINAL.
  - Set err if in_cnt != min(rem,3) or in_last != (rem<=3). Processing stays length-driven; in_cnt and in_last never alter the hash.
- MIX: six lookup3 mix sub-steps with rotations 4, 6, 8, 16, 19, 4, STEPS per cycle. Occupies ceil(6/STEPS) cycles (6/3/2), then LOAD.
- FINAL: seven final sub-steps with rotations 14, 11, 25, 16, 4, 14, 24. Occupies ceil(7/STEPS) cycles (7/4/3); the last cycle may perform fewer than STEPS sub-steps. Then DONE.
- DONE: hash_valid=1, hash_c=c, hash_b=b, hash_err=err, all stable until hash_ready. On hash_valid&&hash_ready go IDLE; cmd_ready rises the next cycle.
- Length 0: no data beats consumed, no final. hash_valid asserts the cycle after command accept with c = init value.
- Latency (STEPS=1), accept-to-hash_valid: 1 + N_full*(1+6) + 1 + 7 beat/stall-free cycles. Example, len=3: accept, 1 beat, 7 final cycles, hash_valid on cycle 9.
- in_valid outside LOAD: ignored, never acked. cmd_valid outside IDLE: ignored.
- Reset mid-operation: all state discarded immediately. No partial result is ever presented.
- All arithmetic is 32-bit wrap-around. Rotations are left rotates by constants, never variable shifters.

Decomposition:
- Package jhash_pkg:
  - state encoding;
  - JHASH_GOLDEN = 32'hdeadbeef;
  - mix rotation table {4,6,8,16,19,4};
  - final rotation table {14,11,25,16,4,14,24}.
- Sub-module jhash_step: purely combinational single sub-step. Inputs a, b, c, step index, mode (mix/final); outputs a', b', c'. The engine chains STEPS instances through a generate loop with step index = base+i, and masks instances beyond the last sub-step to pass-through.

Test Plan:
- len=0, init=0 -> hash_valid one cycle after accept; hash_c=32'hdeadbeef, hash_b=32'hdeadbeef, err=0.
- len=0, init=32'hdeadbeef -> hash_c=32'hbd5b7dde; no in_ready pulse.
- len=3, words {1,2,3}, init=0, STEPS=1 -> no MIX state; hash_valid on cycle 9; hash_c/hash_b equal C hashword2() golden values.
- len=7, random words, STEPS in {1,2,3}, random in_valid/hash_ready stalls -> identical hash_c/hash_b across STEPS, matching the golden model. Exactly 3 beats acked, the last with rem=1.
- len=4, last beat carrying in_cnt=3 and in_last=0 -> hash matches golden (length-driven); hash_err=1.
- rst_n asserted mid-MIX of a len=10 job, then len=1 {32'h0} -> all outputs at reset values; second result matches golden with no residue from the first job.
